// File: rtl/aes_ctrl_fsm.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | aes_ctrl_fsm : sequencing controller for the AES engine and its streamers    |
// | Revision     : 1.0                                                           |
// +-----------------------------------------------------------------------------+

package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    AES_IDLE     = 2'd0,
    AES_STARTING = 2'd1,
    AES_WORKING  = 2'd2,
    AES_FINISHED = 2'd3
  } aes_state_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } stream_flags_t;

  typedef struct packed {
    stream_flags_t plaintext_source_flags;
    stream_flags_t chipertext_sink_flags;
    logic          tcdm_fifo_empty;
  } flags_streamer_t;

  typedef struct packed {
    logic        chipertext_valid;
    logic [15:0] chunk_cnt;
  } flags_engine_t;

  typedef struct packed {
    logic        req_start;
    logic [31:0] base_addr;
    logic [31:0] trans_size;
    logic [15:0] line_stride;
    logic [15:0] line_length;
    logic [15:0] feat_length;
  } stream_ctrl_t;

  typedef struct packed {
    stream_ctrl_t plaintext_source_ctrl;
    stream_ctrl_t chipertext_sink_ctrl;
  } ctrl_streamer_t;

  typedef struct packed {
    logic clear;
    logic enable;
    logic start;
  } ctrl_engine_t;

endpackage

module aes_ctrl_fsm
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NB_WIDTH        = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [31:0]         plaintext_addr_i,
  input  logic [31:0]         ciphertext_addr_i,
  input  logic [NB_WIDTH-1:0] num_blocks_i,
  input  flags_streamer_t     flags_streamer_i,
  input  flags_engine_t       flags_engine_i,
  output ctrl_streamer_t      ctrl_streamer_o,
  output ctrl_engine_t        ctrl_engine_o,
  output aes_state_t          state_o,
  output logic                busy_o,
  output logic                done_o
);

  aes_state_t          state_q, state_d;
  logic [31:0]         paddr_q, paddr_d;
  logic [31:0]         caddr_q, caddr_d;
  logic [NB_WIDTH-1:0] nblk_q, nblk_d;
  logic [NB_WIDTH-1:0] cnt_q, cnt_d;
  logic                sink_seen_q, sink_seen_d;
  logic                zero_done_q, zero_done_d;
  logic                req_go;
  logic                job_exit;
  logic [31:0]         trans_size;

  // Source done and the engine chunk count carry no sequencing information here.
  logic unused_flags;
  assign unused_flags = ^{flags_engine_i.chunk_cnt,
                          flags_streamer_i.plaintext_source_flags.done};

  assign job_exit = (cnt_q == nblk_q)
                  && (sink_seen_q || flags_streamer_i.chipertext_sink_flags.done)
                  && flags_streamer_i.tcdm_fifo_empty;

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    caddr_d     = caddr_q;
    nblk_d      = nblk_q;
    cnt_d       = cnt_q;
    sink_seen_d = sink_seen_q;
    zero_done_d = 1'b0;
    req_go      = 1'b0;

    unique case (state_q)
      AES_IDLE: begin
        if (start_i) begin
          if (num_blocks_i != '0) begin
            paddr_d     = plaintext_addr_i;
            caddr_d     = ciphertext_addr_i;
            nblk_d      = num_blocks_i;
            cnt_d       = '0;
            sink_seen_d = 1'b0;
            state_d     = AES_STARTING;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      AES_STARTING: begin
        if (flags_streamer_i.plaintext_source_flags.ready_start &&
            flags_streamer_i.chipertext_sink_flags.ready_start) begin
          req_go  = 1'b1;
          state_d = AES_WORKING;
        end
      end
      AES_WORKING: begin
        // Counter saturates at the job length so late valids cannot block the exit.
        if (flags_engine_i.chipertext_valid && (cnt_q != nblk_q))
          cnt_d = cnt_q + NB_WIDTH'(1);
        if (flags_streamer_i.chipertext_sink_flags.done)
          sink_seen_d = 1'b1;
        if (job_exit)
          state_d = AES_FINISHED;
      end
      AES_FINISHED: begin
        state_d = AES_IDLE;
      end
      default: begin
        state_d = AES_IDLE;
      end
    endcase

    if (clear_i) begin
      state_d     = AES_IDLE;
      paddr_d     = '0;
      caddr_d     = '0;
      nblk_d      = '0;
      cnt_d       = '0;
      sink_seen_d = 1'b0;
      zero_done_d = 1'b0;
      req_go      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= AES_IDLE;
      paddr_q     <= '0;
      caddr_q     <= '0;
      nblk_q      <= '0;
      cnt_q       <= '0;
      sink_seen_q <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      caddr_q     <= caddr_d;
      nblk_q      <= nblk_d;
      cnt_q       <= cnt_d;
      sink_seen_q <= sink_seen_d;
      zero_done_q <= zero_done_d;
    end
  end

  assign trans_size = 32'(nblk_q) * 32'(WORDS_PER_BLOCK);

  always_comb begin
    ctrl_streamer_o = '0;

    ctrl_streamer_o.plaintext_source_ctrl.req_start   = req_go;
    ctrl_streamer_o.plaintext_source_ctrl.base_addr   = paddr_q;
    ctrl_streamer_o.plaintext_source_ctrl.trans_size  = trans_size;
    ctrl_streamer_o.plaintext_source_ctrl.line_stride = 16'(4 * WORDS_PER_BLOCK);
    ctrl_streamer_o.plaintext_source_ctrl.line_length = 16'(WORDS_PER_BLOCK);
    ctrl_streamer_o.plaintext_source_ctrl.feat_length = 16'd1;

    ctrl_streamer_o.chipertext_sink_ctrl.req_start    = req_go;
    ctrl_streamer_o.chipertext_sink_ctrl.base_addr    = caddr_q;
    ctrl_streamer_o.chipertext_sink_ctrl.trans_size   = trans_size;
    ctrl_streamer_o.chipertext_sink_ctrl.line_stride  = 16'(4 * WORDS_PER_BLOCK);
    ctrl_streamer_o.chipertext_sink_ctrl.line_length  = 16'(WORDS_PER_BLOCK);
    ctrl_streamer_o.chipertext_sink_ctrl.feat_length  = 16'd1;
  end

  always_comb begin
    ctrl_engine_o        = '0;
    ctrl_engine_o.clear  = (state_q == AES_FINISHED);
    ctrl_engine_o.enable = (state_q == AES_WORKING);
    ctrl_engine_o.start  = req_go;
  end

  assign state_o = state_q;
  assign busy_o  = (state_q != AES_IDLE);
  assign done_o  = (state_q == AES_FINISHED) || zero_done_q;

endmodule

`default_nettype wire
